keypad_matrix_emulator: RTL

//  Drives the column side of a 4x4 membrane keypad, answering the row strobes of
//  the keypad scanner as a physical key would. Accepts one key-press request at a

---
 rtl/keypad_matrix_emulator_pkg.sv | 60 ++++++
 rtl/keypad_matrix_emulator_if.sv | 25 ++
 rtl/keypad_bounce_lfsr.sv | 33 +++
 rtl/keypad_matrix_emulator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/keypad_matrix_emulator_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_pkg : key codes, key-to-matrix table and FSM states for the emulator
// Revision 1.0
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [3:0] KEY_ZERO  = 4'd0;
  localparam logic [3:0] KEY_ONE   = 4'd1;
  localparam logic [3:0] KEY_TWO   = 4'd2;
  localparam logic [3:0] KEY_THREE = 4'd3;
  localparam logic [3:0] KEY_FOUR  = 4'd4;
  localparam logic [3:0] KEY_FIVE  = 4'd5;
  localparam logic [3:0] KEY_SIX   = 4'd6;
  localparam logic [3:0] KEY_SEVEN = 4'd7;
  localparam logic [3:0] KEY_EIGHT = 4'd8;
  localparam logic [3:0] KEY_NINE  = 4'd9;
  localparam logic [3:0] KEY_A     = 4'd10;
  localparam logic [3:0] KEY_B     = 4'd11;
  localparam logic [3:0] KEY_C     = 4'd12;
  localparam logic [3:0] KEY_D     = 4'd13;
  localparam logic [3:0] KEY_HASH  = 4'd14;
  localparam logic [3:0] KEY_STAR  = 4'd15;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_MAKE       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  // Matrix index: bits [3:2] select the row group, bits [1:0] the column.
  function automatic logic [3:0] key_idx(input logic [3:0] key);
    logic [3:0] idx;
    case (key)
      KEY_STAR:  idx = 4'd0;
      KEY_ZERO:  idx = 4'd1;
      KEY_HASH:  idx = 4'd2;
      KEY_D:     idx = 4'd3;
      KEY_SEVEN: idx = 4'd4;
      KEY_EIGHT: idx = 4'd5;
      KEY_NINE:  idx = 4'd6;
      KEY_C:     idx = 4'd7;
      KEY_FOUR:  idx = 4'd8;
      KEY_FIVE:  idx = 4'd9;
      KEY_SIX:   idx = 4'd10;
      KEY_B:     idx = 4'd11;
      KEY_ONE:   idx = 4'd12;
      KEY_TWO:   idx = 4'd13;
      KEY_THREE: idx = 4'd14;
      default:   idx = 4'd15;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_emulator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_matrix_emulator_if : request handshake plus row/column matrix lines
// Revision 1.0
// ---------------------------------------------------------------------------
interface keypad_matrix_emulator_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] key_code;
  logic       busy;
  logic       done;

  modport master (
    output row, req_valid, key_code,
    input  col, req_ready, busy, done
  );

  modport slave (
    input  row, req_valid, key_code,
    output col, req_ready, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/keypad_bounce_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_bounce_lfsr : 16-bit Fibonacci LFSR (taps 16,14,13,11) for chatter
// Revision 1.0
// ---------------------------------------------------------------------------
module keypad_bounce_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_en,
  output logic o_bit
);

  logic [15:0] r_state;
  logic [15:0] w_next;
  logic        w_fb;

  assign w_fb   = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];
  assign w_next = {w_fb, r_state[15:1]};
  // Bit of the state being stepped into, so the caller can register it alongside.
  assign o_bit  = w_next[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_emulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_matrix_emulator : answers 4x4 keypad row strobes as a pressed key
// Revision 1.0
// ---------------------------------------------------------------------------
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int          CLOCK_FREQ    = 50_000_000,
  parameter int          HOLD_CYCLES   = 2_000_000,
  parameter int          BOUNCE_CYCLES = 100_000,
  parameter int          GAP_CYCLES    = 1_000_000,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  wire                        clk,
  input  wire                        rst_n,
  keypad_matrix_emulator_if.slave    bus
);

  localparam logic [31:0] c_hold_load   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] c_bounce_load = (BOUNCE_CYCLES == 0) ? 32'd0 : 32'(BOUNCE_CYCLES - 1);
  localparam logic [31:0] c_gap_load    = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic        c_has_bounce  = (BOUNCE_CYCLES != 0);

  if (CLOCK_FREQ < 1 || HOLD_CYCLES < 1 || LFSR_SEED == 16'd0) begin : g_param_check
    $error("keypad_matrix_emulator: illegal parameter value");
  end

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_contact;
  logic [3:0]  r_key;
  logic        r_done;

  logic        w_accept;
  logic        w_cnt_zero;
  logic        w_lfsr_en;
  logic        w_lfsr_bit;
  logic [3:0]  w_idx;
  logic [1:0]  w_grp;
  logic [1:0]  w_bit;
  logic [3:0]  w_col;

  assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
  assign w_cnt_zero = (r_cnt == 32'd0);

  // The LFSR steps on every edge that enters or stays in a bounce cycle.
  always_comb begin
    w_lfsr_en = 1'b0;
    case (r_state)
      ST_IDLE:       w_lfsr_en = w_accept && c_has_bounce;
      ST_BOUNCE_IN:  w_lfsr_en = !w_cnt_zero;
      ST_MAKE:       w_lfsr_en = w_cnt_zero && c_has_bounce;
      ST_BOUNCE_OUT: w_lfsr_en = !w_cnt_zero;
      default:       w_lfsr_en = 1'b0;
    endcase
  end

  keypad_bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_lfsr_en),
    .o_bit (w_lfsr_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 32'd0;
      r_contact <= 1'b0;
      r_key     <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_key <= bus.key_code;
            if (c_has_bounce) begin
              r_state   <= ST_BOUNCE_IN;
              r_cnt     <= c_bounce_load;
              r_contact <= w_lfsr_bit;
            end else begin
              r_state   <= ST_MAKE;
              r_cnt     <= c_hold_load;
              r_contact <= 1'b1;
            end
          end
        end
        ST_BOUNCE_IN: begin
          if (w_cnt_zero) begin
            r_state   <= ST_MAKE;
            r_cnt     <= c_hold_load;
            r_contact <= 1'b1;
          end else begin
            r_cnt     <= r_cnt - 32'd1;
            r_contact <= w_lfsr_bit;
          end
        end
        ST_MAKE: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 32'd1;
          end else if (c_has_bounce) begin
            r_state   <= ST_BOUNCE_OUT;
            r_cnt     <= c_bounce_load;
            r_contact <= w_lfsr_bit;
          end else begin
            r_state   <= ST_GAP;
            r_cnt     <= c_gap_load;
            r_contact <= 1'b0;
          end
        end
        ST_BOUNCE_OUT: begin
          if (w_cnt_zero) begin
            r_state   <= ST_GAP;
            r_cnt     <= c_gap_load;
            r_contact <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - 32'd1;
            r_contact <= w_lfsr_bit;
          end
        end
        ST_GAP: begin
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_contact <= 1'b0;
        end
      endcase
    end
  end

  // Switch-like column path: the row is not registered.
  assign w_idx = key_idx(r_key);
  assign w_grp = w_idx[3:2];
  assign w_bit = w_idx[1:0];

  always_comb begin
    w_col = 4'hF;
    if (r_contact && !bus.row[2'd3 - w_grp]) begin
      w_col[w_bit] = 1'b0;
    end
  end

  assign bus.col       = w_col;
  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;

endmodule
`default_nettype wire
